if_fetch_unit: RTL

- Instruction-fetch front end. Owns the architectural PC register and drives `curr_pc` to the next-PC selector.
- Consumes the selector's `next_pc` and `pipelineFlush`, and issues in-order requests to instruction memory.
- Pairs each memory response with the PC it was fetched from, and hands {pc, inst} to the IF/ID stage through a valid/ready handshake.
- On a flush, squashes buffered and in-flight fetches.

---
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch front end with credit-limited in-order fetch
// PC tags ride a queue alongside requests and are paired with responses into the decode buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] next_pc,
  input  logic        pipelineFlush,
  output logic [31:0] curr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  output logic        protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  out_q, out_d, disc_q, disc_d, buf_cnt_q, buf_cnt_d;
  logic [AW-1:0]  tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;
  logic [31:0]    tag_mem  [DEPTH];
  logic [31:0]    buf_pc   [DEPTH];
  logic [31:0]    buf_inst [DEPTH];
  logic [31:0]    last_pc_q, last_inst_q;
  logic           perr_q;
  logic           req_acc, rsp, rsp_keep, pop;
  logic [CW:0]    credit_used;

  // Credit covers both in-flight requests and buffered results, so the buffer never overflows.
  assign credit_used = {1'b0, out_q} + {1'b0, buf_cnt_q};
  assign imem_req    = (state_q == RUN) && start && !pipelineFlush &&
                       (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = pc_q;
  assign curr_pc     = pc_q;
  assign req_acc     = imem_req && imem_ready;
  assign rsp         = imem_rvalid && (out_q != '0);
  assign rsp_keep    = rsp && (disc_q == '0) && !pipelineFlush;
  assign if_valid    = (buf_cnt_q != '0) && !pipelineFlush;
  assign pop         = if_valid && id_ready;
  assign if_pc       = if_valid ? buf_pc[buf_rd_q]   : last_pc_q;
  assign if_inst     = if_valid ? buf_inst[buf_rd_q] : last_inst_q;
  assign protocol_err = perr_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    disc_d    = disc_q;
    out_d     = out_q + CW'(req_acc) - CW'(rsp);
    buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(pop);
    if (rsp && (disc_q != '0)) disc_d = disc_q - 1'b1;
    if (req_acc) pc_d = next_pc;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!start) state_d = IDLE;
      DRAIN:   if (disc_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (pipelineFlush) begin
      pc_d      = next_pc;
      buf_cnt_d = '0;
      disc_d    = out_q - CW'(rsp);
      if (disc_d != '0) state_d = DRAIN;
      else if (start)   state_d = RUN;
      else              state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_q       <= '0;
      disc_q      <= '0;
      buf_cnt_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      buf_cnt_q <= buf_cnt_d;
      if (req_acc) tag_wr_q <= tag_wr_q + 1'b1;
      if (rsp)     tag_rd_q <= tag_rd_q + 1'b1;
      if (pipelineFlush) begin
        buf_wr_q <= '0;
        buf_rd_q <= '0;
      end else begin
        if (rsp_keep) buf_wr_q <= buf_wr_q + 1'b1;
        if (pop)      buf_rd_q <= buf_rd_q + 1'b1;
      end
      if (if_valid) begin
        last_pc_q   <= buf_pc[buf_rd_q];
        last_inst_q <= buf_inst[buf_rd_q];
      end
      if (imem_rvalid && (out_q == '0)) perr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_keep) begin
      buf_pc[buf_wr_q]   <= tag_mem[tag_rd_q];
      buf_inst[buf_wr_q] <= imem_rdata;
    end
  end
endmodule
